// File: rtl/gf_mul_iter.sv
// rtl/gf_mul_iter.sv - iterative GF(2^WIDTH) multiplier, LANES operands times one shared coefficient
// Shift-and-add with polynomial reduction, BITS_PER_CYCLE coefficient bits per clock.
module gf_mul_iter #(
   parameter int                 WIDTH          = 8,
   parameter logic [WIDTH-1:0]   POLY           = 8'h1B,
   parameter int                 LANES          = 4,
   parameter int                 BITS_PER_CYCLE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   out_p,
   output logic                     busy
);

   localparam int ITER = WIDTH / BITS_PER_CYCLE;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bpc_check
      $error("gf_mul_iter: BITS_PER_CYCLE must divide WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                        state, state_next;
   logic [LANES-1:0][WIDTH-1:0]   a_reg, a_nxt;
   logic [LANES-1:0][WIDTH-1:0]   acc, acc_nxt;
   logic [WIDTH-1:0]              b_reg, b_nxt;
   logic [CW-1:0]                 cnt;

   function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] s;
      s = x << 1;
      return x[WIDTH-1] ? (s ^ POLY) : s;
   endfunction

   // One iteration cycle unrolls BITS_PER_CYCLE shift-and-add steps.
   always_comb begin
      a_nxt   = a_reg;
      b_nxt   = b_reg;
      acc_nxt = acc;
      for (int s = 0; s < BITS_PER_CYCLE; s++) begin
         for (int i = 0; i < LANES; i++) begin
            if (b_nxt[0]) acc_nxt[i] = acc_nxt[i] ^ a_nxt[i];
            a_nxt[i] = xtime(a_nxt[i]);
         end
         b_nxt = b_nxt >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)     state_next = RUN;
         RUN:     if (cnt == LAST)  state_next = DONE;
         DONE:    if (out_ready)    state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
         out_p <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_reg <= in_a;
               b_reg <= in_b;
               acc   <= '0;
               cnt   <= '0;
            end
            RUN: begin
               a_reg <= a_nxt;
               b_reg <= b_nxt;
               acc   <= acc_nxt;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) out_p <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_gf_mul_iter.sv
// tb/tb_gf_mul_iter.sv - self-checking bench for gf_mul_iter
// Two instances: default parameters, and LANES=1 with two coefficient bits per cycle.
module tb_gf_mul_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, busy;
   logic [31:0] in_a = '0, out_p;
   logic [7:0]  in_b = '0;

   logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
   logic        in_ready2, out_valid2, busy2;
   logic [7:0]  in_a2 = '0, in_b2 = '0, out_p2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   gf_mul_iter u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .busy(busy)
   );

   gf_mul_iter #(.WIDTH(8), .POLY(8'h1B), .LANES(1), .BITS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_p(out_p2), .busy(busy2)
   );

   // Reference: full carry-less product, then long division by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int k = 0; k < 8; k++)
         if (b[k]) p = p ^ (16'(a) << k);
      for (int k = 14; k >= 8; k--)
         if (p[k]) p = p ^ (16'h011B << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [31:0] ref_vec(input logic [31:0] a, input logic [7:0] b);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = ref_mul(a[i*8 +: 8], b);
      return r;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [7:0] b,
                         output logic [31:0] p, output int lat);
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom; in_b = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      p = out_p;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_p !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b out_p=%h, want 1 0 0 00000000",
                  in_ready, busy, out_valid, out_p);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lanes();
      logic [31:0] p;
      int lat;
      run_op(32'h01FF8057, 8'h02, p, lat);
      total++;
      if (p !== 32'h02E51BAE) begin
         bad++;
         $display("FAIL lanes_x02: out_p=%h want 02e51bae", p);
      end
      total++;
      if (lat !== 8) begin
         bad++;
         $display("FAIL lanes_latency: got %0d want 8", lat);
      end
      release_result();
   endtask

   task automatic test_vectors();
      logic [7:0] bs [4] = '{8'h83, 8'h13, 8'h00, 8'h01};
      logic [7:0] ex [4] = '{8'hC1, 8'hFE, 8'h00, 8'h57};
      logic [31:0] a, p;
      int lat;
      for (int t = 0; t < 4; t++) begin
         a = {24'($urandom), 8'h57};
         run_op(a, bs[t], p, lat);
         total++;
         if (p[7:0] !== ex[t]) begin
            bad++;
            $display("FAIL fips_lane0 b=%h: got %h want %h", bs[t], p[7:0], ex[t]);
         end
         total++;
         if (p !== ref_vec(a, bs[t])) begin
            bad++;
            $display("FAIL fips_all_lanes b=%h: got %h want %h", bs[t], p, ref_vec(a, bs[t]));
         end
         total++;
         if (lat !== 8) begin
            bad++;
            $display("FAIL fips_latency b=%h: got %0d want 8", bs[t], lat);
         end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, p, p2;
      int lat;
      a = $urandom;
      run_op(a, 8'h13, p, lat);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            in_valid = 1'b1; in_a = 32'hDEADBEEF; in_b = 8'h5A;
         end
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || out_p !== p || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: out_valid=%b out_p=%h in_ready=%b want 1 %h 0",
                     c, out_valid, out_p, in_ready, p);
         end
      end
      total++;
      if (p !== ref_vec(a, 8'h13)) begin
         bad++;
         $display("FAIL bp_result: got %h want %h", p, ref_vec(a, 8'h13));
      end
      release_result();
      repeat (2) @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_p !== p) begin
         bad++;
         $display("FAIL bp_no_queue: in_ready=%b busy=%b out_p=%h want 1 0 %h", in_ready, busy, out_p, p);
      end
      run_op(32'h11223344, 8'h09, p2, lat);
      total++;
      if (p2 !== ref_vec(32'h11223344, 8'h09) || lat !== 8) begin
         bad++;
         $display("FAIL bp_next_op: got %h lat %0d want %h lat 8", p2, lat, ref_vec(32'h11223344, 8'h09));
      end
      release_result();
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] p;
      int lat;
      @(negedge clk);
      in_a = 32'hA5C3_0F57; in_b = 8'h83; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_p !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_run: out_valid=%b out_p=%h in_ready=%b busy=%b want 0 00000000 1 0",
                  out_valid, out_p, in_ready, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_result: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
      run_op(32'h00000057, 8'h83, p, lat);
      total++;
      if (p[7:0] !== 8'hC1 || lat !== 8) begin
         bad++;
         $display("FAIL reset_fresh_op: got %h lat %0d want c1 lat 8", p[7:0], lat);
      end
      release_result();
   endtask

   task automatic test_bpc2();
      logic [7:0] a, b;
      int lat;
      for (int t = 0; t < 6; t++) begin
         a = (t == 0) ? 8'h57 : 8'($urandom);
         b = (t == 0) ? 8'h0E : 8'($urandom);
         @(negedge clk);
         in_a2 = a; in_b2 = b; in_valid2 = 1'b1;
         @(negedge clk);
         in_valid2 = 1'b0;
         lat = 0;
         while (!out_valid2 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         total++;
         if (out_p2 !== ref_mul(a, b) || lat !== 4) begin
            bad++;
            $display("FAIL bpc2 %h*%h: got %h lat %0d want %h lat 4", a, b, out_p2, lat, ref_mul(a, b));
         end
         out_ready2 = 1'b1;
         @(negedge clk);
         out_ready2 = 1'b0;
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_q [$];
      logic [31:0] a, exp_p;
      logic [7:0]  b;
      int done_cnt = 0;
      int cyc = 0;
      const int n_ops = 1500;
      while (done_cnt < n_ops && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         a = $urandom; b = 8'($urandom);
         in_a = a; in_b = b;
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 1) == 1);
         if (in_valid && in_ready) exp_q.push_back(ref_vec(a, b));
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rand_duplicate: unexpected result %h", out_p);
            end else begin
               exp_p = exp_q.pop_front();
               if (out_p !== exp_p) begin
                  bad++;
                  $display("FAIL rand_product #%0d: got %h want %h", done_cnt, out_p, exp_p);
               end
            end
            done_cnt++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (done_cnt != n_ops || exp_q.size() > 1) begin
         bad++;
         $display("FAIL rand_complete: results=%0d pending=%0d want %0d and at most 1 in flight",
                  done_cnt, exp_q.size(), n_ops);
      end
   endtask

   initial begin
      test_reset();
      test_lanes();
      test_vectors();
      test_backpressure();
      test_reset_mid_run();
      test_bpc2();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
